// File: rtl/video_window_scaler.sv
// Maps a raster window onto an RGB565 frame buffer with 1x/2x/4x pixel
// replication, background fill outside the window and RGB888 expansion.
module video_window_scaler #(
   parameter int IMAGE_SIZE_H = 256,
   parameter int IMAGE_SIZE_V = 384,
   parameter int ADDR_W       = 17,
   parameter int COORD_W      = 12,
   parameter int RD_LATENCY   = 1
) (
   input  logic               i_clk_pixel,
   input  logic               i_rstn,
   input  logic [COORD_W-1:0] i_offset_x,
   input  logic [COORD_W-1:0] i_offset_y,
   input  logic [1:0]         i_scale_mode,
   input  logic               i_fmt_mode,
   input  logic [23:0]        i_bg_color,
   input  logic               i_rgb_vde,
   input  logic               i_rgb_hsync,
   input  logic               i_rgb_vsync,
   input  logic [COORD_W-1:0] i_set_x,
   input  logic [COORD_W-1:0] i_set_y,
   output logic [ADDR_W-1:0]  o_rd_addr,
   output logic               o_rd_en,
   input  logic [15:0]        i_rd_data,
   output logic [23:0]        o_video_data,
   output logic               o_video_vde,
   output logic               o_video_hsync,
   output logic               o_video_vsync
);

   localparam int EXT_W  = COORD_W + 3;
   localparam int PIPE_D = RD_LATENCY + 1;
   localparam int CTRL_W = 5;
   localparam int C_VDE  = 4;
   localparam int C_HS   = 3;
   localparam int C_VS   = 2;
   localparam int C_WIN  = 1;
   localparam int C_FMT  = 0;

   logic [COORD_W-1:0] off_x_reg, off_y_reg;
   logic [1:0]         scale_mode_reg;
   logic               fmt_reg;
   logic [23:0]        bg_reg;
   logic               vsync_d_reg, vde_d_reg;

   logic [ADDR_W-1:0]  row_base_reg, col_reg;
   logic [1:0]         x_sub_reg, y_sub_reg;
   logic               line_hit_reg;

   logic [1:0]         scale_shift, sub_max;
   logic [EXT_W-1:0]   win_w, win_h;
   logic [EXT_W-1:0]   x_ext, y_ext, off_x_ext, off_y_ext;
   logic               in_win, vsync_rise, line_end;
   logic [ADDR_W-1:0]  rd_addr_next;
   logic [CTRL_W-1:0]  ctrl_in, ctrl_out;
   logic [23:0]        expanded;

   always_comb begin
      scale_shift = 2'd0;
      sub_max     = 2'd0;
      case (scale_mode_reg)
         2'b01:   begin scale_shift = 2'd1; sub_max = 2'd1; end
         2'b10:   begin scale_shift = 2'd2; sub_max = 2'd3; end
         default: begin scale_shift = 2'd0; sub_max = 2'd0; end
      endcase
   end

   // Widened compare so window edges past the raster clip instead of wrapping
   assign win_w     = EXT_W'(IMAGE_SIZE_H) << scale_shift;
   assign win_h     = EXT_W'(IMAGE_SIZE_V) << scale_shift;
   assign x_ext     = EXT_W'(i_set_x);
   assign y_ext     = EXT_W'(i_set_y);
   assign off_x_ext = EXT_W'(off_x_reg);
   assign off_y_ext = EXT_W'(off_y_reg);

   assign in_win = i_rgb_vde
                 && (x_ext >= off_x_ext) && (x_ext < off_x_ext + win_w)
                 && (y_ext >= off_y_ext) && (y_ext < off_y_ext + win_h);

   assign vsync_rise   = i_rgb_vsync & ~vsync_d_reg;
   assign line_end     = vde_d_reg & ~i_rgb_vde;
   assign rd_addr_next = row_base_reg + col_reg;

   always_ff @(posedge i_clk_pixel or negedge i_rstn) begin
      if (!i_rstn) begin
         off_x_reg      <= '0;
         off_y_reg      <= '0;
         scale_mode_reg <= 2'b00;
         fmt_reg        <= 1'b0;
         bg_reg         <= 24'h000000;
         vsync_d_reg    <= 1'b0;
         vde_d_reg      <= 1'b0;
         row_base_reg   <= '0;
         col_reg        <= '0;
         x_sub_reg      <= 2'd0;
         y_sub_reg      <= 2'd0;
         line_hit_reg   <= 1'b0;
      end else begin
         vsync_d_reg <= i_rgb_vsync;
         vde_d_reg   <= i_rgb_vde;
         if (vsync_rise) begin
            off_x_reg      <= i_offset_x;
            off_y_reg      <= i_offset_y;
            scale_mode_reg <= i_scale_mode;
            fmt_reg        <= i_fmt_mode;
            bg_reg         <= i_bg_color;
            row_base_reg   <= '0;
            col_reg        <= '0;
            x_sub_reg      <= 2'd0;
            y_sub_reg      <= 2'd0;
            line_hit_reg   <= 1'b0;
         end else if (line_end) begin
            col_reg      <= '0;
            x_sub_reg    <= 2'd0;
            line_hit_reg <= 1'b0;
            // Only lines that touched the window count towards the row step
            if (line_hit_reg) begin
               if (y_sub_reg == sub_max) begin
                  y_sub_reg    <= 2'd0;
                  row_base_reg <= row_base_reg + ADDR_W'(IMAGE_SIZE_H);
               end else begin
                  y_sub_reg <= y_sub_reg + 2'd1;
               end
            end
         end else if (in_win) begin
            line_hit_reg <= 1'b1;
            if (x_sub_reg == sub_max) begin
               x_sub_reg <= 2'd0;
               col_reg   <= col_reg + ADDR_W'(1);
            end else begin
               x_sub_reg <= x_sub_reg + 2'd1;
            end
         end
      end
   end

   always_ff @(posedge i_clk_pixel or negedge i_rstn) begin
      if (!i_rstn) begin
         o_rd_en   <= 1'b0;
         o_rd_addr <= '0;
      end else begin
         o_rd_en <= in_win;
         if (in_win) begin
            o_rd_addr <= rd_addr_next;
         end
      end
   end

   // Timing, window flag and format travel with the read so selection lines up with data
   assign ctrl_in = {i_rgb_vde, i_rgb_hsync, i_rgb_vsync, in_win, fmt_reg};

   genvar gi;
   generate
      for (gi = 0; gi < PIPE_D; gi++) begin : g_stage
         logic [CTRL_W-1:0] ctrl_reg;
         logic [CTRL_W-1:0] ctrl_src;
         if (gi == 0) begin : g_head
            assign ctrl_src = ctrl_in;
         end else begin : g_tail
            assign ctrl_src = g_stage[gi-1].ctrl_reg;
         end
         always_ff @(posedge i_clk_pixel or negedge i_rstn) begin
            if (!i_rstn) begin
               ctrl_reg <= '0;
            end else begin
               ctrl_reg <= ctrl_src;
            end
         end
      end
   endgenerate

   assign ctrl_out = g_stage[PIPE_D-1].ctrl_reg;

   assign expanded = ctrl_out[C_FMT]
      ? {i_rd_data[15:11], i_rd_data[15:13], i_rd_data[10:5], i_rd_data[10:9],
         i_rd_data[4:0], i_rd_data[4:2]}
      : {i_rd_data[15:11], 3'b000, i_rd_data[10:5], 2'b00, i_rd_data[4:0], 3'b000};

   always_ff @(posedge i_clk_pixel or negedge i_rstn) begin
      if (!i_rstn) begin
         o_video_data  <= 24'h000000;
         o_video_vde   <= 1'b0;
         o_video_hsync <= 1'b0;
         o_video_vsync <= 1'b0;
      end else begin
         o_video_vde   <= ctrl_out[C_VDE];
         o_video_hsync <= ctrl_out[C_HS];
         o_video_vsync <= ctrl_out[C_VS];
         if (ctrl_out[C_WIN]) begin
            o_video_data <= expanded;
         end else if (ctrl_out[C_VDE]) begin
            o_video_data <= bg_reg;
         end else begin
            o_video_data <= 24'h000000;
         end
      end
   end

endmodule

// File: tb/tb_video_window_scaler.sv
// Directed bench: drives partial raster lines into two scaler instances
// (read latency 1 and 3) and compares reads and pixels with hand values.
`timescale 1ns/1ps
module tb_video_window_scaler;

   localparam int REC_N = 65536;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [11:0] offset_x = '0, offset_y = '0, set_x = '0, set_y = '0;
   logic [1:0]  scale_mode = 2'b00;
   logic        fmt_mode = 1'b0;
   logic [23:0] bg_color = '0;
   logic        vde = 1'b0, hsync = 1'b0, vsync = 1'b0;

   logic [16:0] rd_addr_a, rd_addr_b;
   logic        rd_en_a, rd_en_b;
   logic [15:0] rd_data_a, rd_data_b;
   logic [23:0] vdata_a, vdata_b;
   logic        vvde_a, vhs_a, vvs_a, vvde_b, vhs_b, vvs_b;

   logic        force_en = 1'b0;
   logic [15:0] force_val = 16'hF81F;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int lc [1024];
   int hs_cyc = 0;
   int vs_cyc = 0;

   logic [16:0] rec_addr_a [REC_N];
   logic        rec_en_a   [REC_N];
   logic [23:0] rec_data_a [REC_N];
   logic        rec_vde_a  [REC_N];
   logic        rec_hs_a   [REC_N];
   logic        rec_vs_a   [REC_N];
   logic [23:0] rec_data_b [REC_N];
   logic        rec_vde_b  [REC_N];

   video_window_scaler #(.RD_LATENCY(1)) dut_a (
      .i_clk_pixel(clk), .i_rstn(rstn),
      .i_offset_x(offset_x), .i_offset_y(offset_y),
      .i_scale_mode(scale_mode), .i_fmt_mode(fmt_mode), .i_bg_color(bg_color),
      .i_rgb_vde(vde), .i_rgb_hsync(hsync), .i_rgb_vsync(vsync),
      .i_set_x(set_x), .i_set_y(set_y),
      .o_rd_addr(rd_addr_a), .o_rd_en(rd_en_a), .i_rd_data(rd_data_a),
      .o_video_data(vdata_a), .o_video_vde(vvde_a),
      .o_video_hsync(vhs_a), .o_video_vsync(vvs_a)
   );

   video_window_scaler #(.RD_LATENCY(3)) dut_b (
      .i_clk_pixel(clk), .i_rstn(rstn),
      .i_offset_x(offset_x), .i_offset_y(offset_y),
      .i_scale_mode(scale_mode), .i_fmt_mode(fmt_mode), .i_bg_color(bg_color),
      .i_rgb_vde(vde), .i_rgb_hsync(hsync), .i_rgb_vsync(vsync),
      .i_set_x(set_x), .i_set_y(set_y),
      .o_rd_addr(rd_addr_b), .o_rd_en(rd_en_b), .i_rd_data(rd_data_b),
      .o_video_data(vdata_b), .o_video_vde(vvde_b),
      .o_video_hsync(vhs_b), .o_video_vsync(vvs_b)
   );

   always #5 clk = ~clk;

   // Frame-buffer models: data = address[15:0] unless overridden
   logic [15:0] mem_a;
   logic [15:0] mem_b [3];
   always @(posedge clk) begin
      mem_a    <= force_en ? force_val : rd_addr_a[15:0];
      mem_b[0] <= force_en ? force_val : rd_addr_b[15:0];
      mem_b[1] <= mem_b[0];
      mem_b[2] <= mem_b[1];
   end
   assign rd_data_a = mem_a;
   assign rd_data_b = mem_b[2];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      int i;
      i = cyc % REC_N;
      rec_addr_a[i] = rd_addr_a;
      rec_en_a[i]   = rd_en_a;
      rec_data_a[i] = vdata_a;
      rec_vde_a[i]  = vvde_a;
      rec_hs_a[i]   = vhs_a;
      rec_vs_a[i]   = vvs_a;
      rec_data_b[i] = vdata_b;
      rec_vde_b[i]  = vvde_b;
   end

   function automatic int idx(input int c);
      return c % REC_N;
   endfunction

   task automatic drive_line(input int y, input int x0, input int x1);
      for (int x = x0; x <= x1; x++) begin
         @(negedge clk);
         set_x = 12'(x); set_y = 12'(y); vde = 1'b1; hsync = 1'b0;
         lc[x] = cyc;
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         vde = 1'b0;
         hsync = (i == 1 || i == 2);
         if (i == 1) hs_cyc = cyc;
      end
   endtask

   task automatic frame_start();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         vde = 1'b0; hsync = 1'b0;
         vsync = (i >= 2 && i <= 4);
         if (i == 2) vs_cyc = cyc;
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (rd_en_a !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", rd_en_a); end
      checks++; if (rd_addr_a !== 17'd0) begin errors++; $display("FAIL reset_rd_addr: got %0h want 0", rd_addr_a); end
      checks++; if (vdata_a !== 24'h0) begin errors++; $display("FAIL reset_vdata: got %h want 000000", vdata_a); end
      checks++; if ({vvde_a, vhs_a, vvs_a} !== 3'b000) begin errors++; $display("FAIL reset_timing: got %b want 000", {vvde_a, vhs_a, vvs_a}); end
      checks++; if (vdata_b !== 24'h0) begin errors++; $display("FAIL reset_vdata_b: got %h want 000000", vdata_b); end
      @(negedge clk);
      rstn = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_default();
      offset_x = 0; offset_y = 0; scale_mode = 2'b00; fmt_mode = 1'b0; bg_color = 24'h123456;
      frame_start();
      drive_line(0, 0, 259);
      checks++; if (rec_vs_a[idx(vs_cyc+3)] !== 1'b1 || rec_vs_a[idx(vs_cyc+2)] !== 1'b0) begin errors++; $display("FAIL dflt_vsync_delay: got %b%b want 01", rec_vs_a[idx(vs_cyc+2)], rec_vs_a[idx(vs_cyc+3)]); end
      checks++; if (rec_en_a[idx(lc[0]+1)] !== 1'b1) begin errors++; $display("FAIL dflt_rd_en_0: got %b want 1", rec_en_a[idx(lc[0]+1)]); end
      checks++; if (rec_addr_a[idx(lc[0]+1)] !== 17'd0) begin errors++; $display("FAIL dflt_rd_addr_0: got %0d want 0", rec_addr_a[idx(lc[0]+1)]); end
      checks++; if (rec_vde_a[idx(lc[0]+3)] !== 1'b1 || rec_vde_a[idx(lc[0]+2)] !== 1'b0) begin errors++; $display("FAIL dflt_vde_delay: got %b%b want 01", rec_vde_a[idx(lc[0]+2)], rec_vde_a[idx(lc[0]+3)]); end
      checks++; if (rec_data_a[idx(lc[1]+3)] !== 24'h000008) begin errors++; $display("FAIL dflt_data_1: got %h want 000008", rec_data_a[idx(lc[1]+3)]); end
      checks++; if (rec_en_a[idx(lc[256]+1)] !== 1'b0) begin errors++; $display("FAIL dflt_rd_en_256: got %b want 0", rec_en_a[idx(lc[256]+1)]); end
      checks++; if (rec_addr_a[idx(lc[256]+1)] !== 17'd255) begin errors++; $display("FAIL dflt_addr_hold: got %0d want 255", rec_addr_a[idx(lc[256]+1)]); end
      checks++; if (rec_data_a[idx(lc[256]+3)] !== 24'h123456) begin errors++; $display("FAIL dflt_bg_256: got %h want 123456", rec_data_a[idx(lc[256]+3)]); end
      checks++; if (rec_hs_a[idx(hs_cyc+3)] !== 1'b1 || rec_hs_a[idx(hs_cyc+2)] !== 1'b0) begin errors++; $display("FAIL dflt_hsync_delay: got %b%b want 01", rec_hs_a[idx(hs_cyc+2)], rec_hs_a[idx(hs_cyc+3)]); end
      checks++; if (rec_data_a[idx(hs_cyc+3)] !== 24'h000000) begin errors++; $display("FAIL dflt_blank_black: got %h want 000000", rec_data_a[idx(hs_cyc+3)]); end
      drive_line(1, 0, 259);
      checks++; if (rec_addr_a[idx(lc[255]+1)] !== 17'd511) begin errors++; $display("FAIL dflt_addr_255_1: got %0d want 511", rec_addr_a[idx(lc[255]+1)]); end
      checks++; if (rec_data_a[idx(lc[255]+3)] !== 24'h003CF8) begin errors++; $display("FAIL dflt_data_255_1: got %h want 003cf8", rec_data_a[idx(lc[255]+3)]); end
   endtask

   task automatic test_scale2x();
      offset_x = 100; offset_y = 50; scale_mode = 2'b01; bg_color = 24'h00FF00;
      frame_start();
      for (int y = 50; y <= 767; y++) begin
         drive_line(y, 96, (y == 54) ? 615 : 103);
         if (y == 50) begin
            checks++; if (rec_en_a[idx(lc[99]+1)] !== 1'b0) begin errors++; $display("FAIL s2_en_99_50: got %b want 0", rec_en_a[idx(lc[99]+1)]); end
            checks++; if (rec_data_a[idx(lc[99]+3)] !== 24'h00FF00) begin errors++; $display("FAIL s2_bg_99_50: got %h want 00ff00", rec_data_a[idx(lc[99]+3)]); end
            checks++; if (rec_en_a[idx(lc[100]+1)] !== 1'b1 || rec_addr_a[idx(lc[100]+1)] !== 17'd0) begin errors++; $display("FAIL s2_addr_100_50: got en=%b %0d want en=1 0", rec_en_a[idx(lc[100]+1)], rec_addr_a[idx(lc[100]+1)]); end
            checks++; if (rec_addr_a[idx(lc[102]+1)] !== 17'd1) begin errors++; $display("FAIL s2_addr_102_50: got %0d want 1", rec_addr_a[idx(lc[102]+1)]); end
            checks++; if (rec_data_a[idx(lc[102]+3)] !== 24'h000008) begin errors++; $display("FAIL s2_data_102_50: got %h want 000008", rec_data_a[idx(lc[102]+3)]); end
         end
         if (y == 51) begin
            checks++; if (rec_addr_a[idx(lc[101]+1)] !== 17'd0) begin errors++; $display("FAIL s2_addr_101_51: got %0d want 0", rec_addr_a[idx(lc[101]+1)]); end
         end
         if (y == 52) begin
            checks++; if (rec_addr_a[idx(lc[100]+1)] !== 17'd256) begin errors++; $display("FAIL s2_addr_100_52: got %0d want 256", rec_addr_a[idx(lc[100]+1)]); end
         end
         if (y == 54) begin
            checks++; if (rec_en_a[idx(lc[611]+1)] !== 1'b1 || rec_addr_a[idx(lc[611]+1)] !== 17'd767) begin errors++; $display("FAIL s2_addr_611_54: got en=%b %0d want en=1 767", rec_en_a[idx(lc[611]+1)], rec_addr_a[idx(lc[611]+1)]); end
            checks++; if (rec_en_a[idx(lc[612]+1)] !== 1'b0) begin errors++; $display("FAIL s2_en_612_54: got %b want 0", rec_en_a[idx(lc[612]+1)]); end
         end
         if (y == 767) begin
            checks++; if (rec_addr_a[idx(lc[100]+1)] !== 17'd91648) begin errors++; $display("FAIL s2_addr_100_767: got %0d want 91648", rec_addr_a[idx(lc[100]+1)]); end
         end
      end
   endtask

   task automatic test_clip();
      int hits;
      hits = 0;
      offset_x = 1000; offset_y = 700; scale_mode = 2'b00;
      frame_start();
      for (int y = 698; y <= 767; y++) begin
         drive_line(y, 996, 1023);
         for (int x = 996; x <= 1023; x++) if (rec_en_a[idx(lc[x]+1)] === 1'b1) hits++;
         if (y == 699) begin
            checks++; if (rec_en_a[idx(lc[1000]+1)] !== 1'b0) begin errors++; $display("FAIL clip_en_1000_699: got %b want 0", rec_en_a[idx(lc[1000]+1)]); end
         end
         if (y == 700) begin
            checks++; if (rec_en_a[idx(lc[999]+1)] !== 1'b0) begin errors++; $display("FAIL clip_en_999_700: got %b want 0", rec_en_a[idx(lc[999]+1)]); end
            checks++; if (rec_addr_a[idx(lc[1000]+1)] !== 17'd0) begin errors++; $display("FAIL clip_addr_1000_700: got %0d want 0", rec_addr_a[idx(lc[1000]+1)]); end
         end
         if (y == 767) begin
            checks++; if (rec_addr_a[idx(lc[1023]+1)] !== 17'd17175) begin errors++; $display("FAIL clip_addr_1023_767: got %0d want 17175", rec_addr_a[idx(lc[1023]+1)]); end
         end
      end
      checks++; if (hits != 1632) begin errors++; $display("FAIL clip_read_count: got %0d want 1632", hits); end
   endtask

   task automatic test_fmt();
      offset_x = 0; offset_y = 0; scale_mode = 2'b00; fmt_mode = 1'b0;
      force_en = 1'b1;
      frame_start();
      drive_line(0, 0, 7);
      checks++; if (rec_data_a[idx(lc[2]+3)] !== 24'hF800F8) begin errors++; $display("FAIL fmt0_data_a: got %h want f800f8", rec_data_a[idx(lc[2]+3)]); end
      checks++; if (rec_data_b[idx(lc[2]+5)] !== 24'hF800F8) begin errors++; $display("FAIL fmt0_data_b: got %h want f800f8", rec_data_b[idx(lc[2]+5)]); end
      fmt_mode = 1'b1;
      frame_start();
      drive_line(0, 0, 7);
      checks++; if (rec_data_a[idx(lc[2]+3)] !== 24'hFF00FF) begin errors++; $display("FAIL fmt1_data_a: got %h want ff00ff", rec_data_a[idx(lc[2]+3)]); end
      checks++; if (rec_data_b[idx(lc[2]+5)] !== 24'hFF00FF) begin errors++; $display("FAIL fmt1_data_b: got %h want ff00ff", rec_data_b[idx(lc[2]+5)]); end
      force_en = 1'b0;
      frame_start();
      drive_line(0, 0, 7);
      checks++; if (rec_data_b[idx(lc[5]+5)] !== 24'h000029) begin errors++; $display("FAIL lat3_data_5: got %h want 000029", rec_data_b[idx(lc[5]+5)]); end
      checks++; if (rec_data_b[idx(lc[5]+4)] !== 24'h000021) begin errors++; $display("FAIL lat3_data_4: got %h want 000021", rec_data_b[idx(lc[5]+4)]); end
      checks++; if (rec_vde_b[idx(lc[0]+5)] !== 1'b1 || rec_vde_b[idx(lc[0]+4)] !== 1'b0) begin errors++; $display("FAIL lat3_vde_delay: got %b%b want 01", rec_vde_b[idx(lc[0]+4)], rec_vde_b[idx(lc[0]+5)]); end
   endtask

   task automatic test_midframe_scale();
      scale_mode = 2'b00; fmt_mode = 1'b0;
      frame_start();
      drive_line(0, 0, 7);
      scale_mode = 2'b01;
      drive_line(1, 0, 7);
      checks++; if (rec_addr_a[idx(lc[3]+1)] !== 17'd259) begin errors++; $display("FAIL mid_addr_3_1_old: got %0d want 259", rec_addr_a[idx(lc[3]+1)]); end
      frame_start();
      drive_line(0, 0, 7);
      checks++; if (rec_addr_a[idx(lc[3]+1)] !== 17'd1) begin errors++; $display("FAIL mid_addr_3_0_new: got %0d want 1", rec_addr_a[idx(lc[3]+1)]); end
      drive_line(1, 0, 7);
      checks++; if (rec_addr_a[idx(lc[3]+1)] !== 17'd1) begin errors++; $display("FAIL mid_addr_3_1_new: got %0d want 1", rec_addr_a[idx(lc[3]+1)]); end
      drive_line(2, 0, 7);
      checks++; if (rec_addr_a[idx(lc[2]+1)] !== 17'd257) begin errors++; $display("FAIL mid_addr_2_2_new: got %0d want 257", rec_addr_a[idx(lc[2]+1)]); end
   endtask

   task automatic test_reset_midline();
      bg_color = 24'hABCDEF;
      frame_start();
      for (int x = 0; x <= 9; x++) begin
         @(negedge clk);
         set_x = 12'(x); set_y = 12'd0; vde = 1'b1;
      end
      #2;
      checks++; if (vvde_a !== 1'b1 || rd_addr_a !== 17'd4) begin errors++; $display("FAIL rst_pre_state: got vde=%b addr=%0d want vde=1 addr=4", vvde_a, rd_addr_a); end
      rstn = 1'b0;
      #1;
      checks++; if (rd_en_a !== 1'b0 || rd_addr_a !== 17'd0) begin errors++; $display("FAIL rst_mid_rd: got en=%b addr=%0d want 0 0", rd_en_a, rd_addr_a); end
      checks++; if (vdata_a !== 24'h0 || vvde_a !== 1'b0) begin errors++; $display("FAIL rst_mid_video_a: got %h vde=%b want 000000 0", vdata_a, vvde_a); end
      checks++; if (vdata_b !== 24'h0 || vvde_b !== 1'b0) begin errors++; $display("FAIL rst_mid_video_b: got %h vde=%b want 000000 0", vdata_b, vvde_b); end
      @(negedge clk);
      vde = 1'b0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      repeat (2) @(negedge clk);
      drive_line(0, 0, 7);
      checks++; if (rec_addr_a[idx(lc[3]+1)] !== 17'd3) begin errors++; $display("FAIL rst_default_addr: got %0d want 3", rec_addr_a[idx(lc[3]+1)]); end
      scale_mode = 2'b00; fmt_mode = 1'b0; bg_color = 24'h000000; offset_x = 0; offset_y = 0;
      frame_start();
      drive_line(0, 0, 7);
      drive_line(1, 0, 7);
      checks++; if (rec_addr_a[idx(lc[1]+1)] !== 17'd257) begin errors++; $display("FAIL rst_frame_addr: got %0d want 257", rec_addr_a[idx(lc[1]+1)]); end
      checks++; if (rec_data_a[idx(lc[1]+3)] !== 24'h002008) begin errors++; $display("FAIL rst_frame_data: got %h want 002008", rec_data_a[idx(lc[1]+3)]); end
   endtask

   initial begin
      test_reset();
      test_default();
      test_scale2x();
      test_clip();
      test_fmt();
      test_midframe_scale();
      test_reset_midline();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not complete within time limit");
      $fatal(1, "timeout");
   end

endmodule
